dmrs_ch_avg_acc: RTL and testbench

- Parametrised multi-symbol channel-estimate averager; successor to the fixed 3-symbol PBCH averaging stage.
- Sits between the MMSE stage and the equaliser and accepts per-RE I/Q estimates tagged with an RE index.
- Accumulates each index over up to MAX_SYMBOLS DMRS symbols, normalises by that index's own hit count, streams the averages out and keeps them for random-access equaliser reads.
- Per-entry hit counts handle symbols with unequal DMRS coverage (e.g. PBCH middle symbol).

---
 rtl/dmrs_ch_avg_acc_pkg.sv | 31 +++
 rtl/dmrs_ch_avg_acc_norm.sv | 70 +++++++
 rtl/dmrs_ch_avg_acc.sv | 241 ++++++++++++++++++++++++
 tb/tb_dmrs_ch_avg_acc.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmrs_ch_avg_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ch_avg_pkg
// Purpose  : Shared types and constant helpers for the DMRS channel averager.
// Revision : 1.0 - initial release
// ============================================================================
package ch_avg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ACCUM = 3'd2,
        ST_NORM  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Headroom for summing max_symbols full-scale samples without wrap.
    function automatic int acc_width(input int word_length, input int max_symbols);
        return word_length + $clog2(max_symbols);
    endfunction

    // round(2^frac / c); entry 0 maps to 0 so an unwritten entry averages to 0.
    function automatic int recip(input int c, input int frac);
        if (c <= 0) begin
            return 0;
        end
        return ((1 << frac) + (c / 2)) / c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmrs_ch_avg_acc_norm.sv
`default_nettype none
// ============================================================================
// Module   : ch_avg_norm
// Purpose  : Registered scale/shift/saturate stage for one accumulator lane.
//            CH_AVG_ROUND_EN adds round-half-up before the shift.
// Revision : 1.0 - initial release
// ============================================================================
module ch_avg_norm #(
    parameter int WORD_LENGTH = 8,
    parameter int ACC_W       = 10,
    parameter int RECIP_W     = 13,
    parameter int RECIP_FRAC  = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_i,
    input  logic signed [ACC_W-1:0]       acc_i,
    input  logic        [RECIP_W-1:0]     recip_i,
    output logic        [WORD_LENGTH-1:0] avg_d_o,
    output logic        [WORD_LENGTH-1:0] avg_q_o
);

    localparam int PW = ACC_W + RECIP_W + 1;
    localparam logic signed [PW-1:0] SAT_HI = {{(PW-WORD_LENGTH+1){1'b0}}, {(WORD_LENGTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_LO = {{(PW-WORD_LENGTH+1){1'b1}}, {(WORD_LENGTH-1){1'b0}}};

    logic signed [PW-1:0]          w_acc_ext;
    logic signed [PW-1:0]          w_recip_ext;
    logic signed [PW-1:0]          w_prod;
    logic signed [PW-1:0]          w_sum;
    logic signed [PW-1:0]          w_shift;
    logic        [WORD_LENGTH-1:0] w_avg;
    logic        [WORD_LENGTH-1:0] avg_q;

    assign w_acc_ext   = PW'(acc_i);
    assign w_recip_ext = PW'(recip_i);
    assign w_prod      = w_acc_ext * w_recip_ext;

`ifdef CH_AVG_ROUND_EN
    localparam logic signed [PW-1:0] ROUND_HALF = {{(PW-RECIP_FRAC){1'b0}}, 1'b1, {(RECIP_FRAC-1){1'b0}}};
    assign w_sum = w_prod + ROUND_HALF;
`else
    assign w_sum = w_prod;
`endif

    assign w_shift = w_sum >>> RECIP_FRAC;

    // Reciprocals are rounded, so a full-scale average can land one LSB outside range.
    always_comb begin
        w_avg = w_shift[WORD_LENGTH-1:0];
        if (w_shift > SAT_HI) begin
            w_avg = {1'b0, {(WORD_LENGTH-1){1'b1}}};
        end else if (w_shift < SAT_LO) begin
            w_avg = {1'b1, {(WORD_LENGTH-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            avg_q <= '0;
        end else if (valid_i) begin
            avg_q <= w_avg;
        end
    end

    assign avg_d_o = w_avg;
    assign avg_q_o = avg_q;

endmodule
`default_nettype wire

// File: rtl/dmrs_ch_avg_acc.sv
`default_nettype none
// ============================================================================
// Module   : dmrs_ch_avg_acc
// Purpose  : Multi-symbol DMRS channel-estimate averager with per-entry hit
//            counts, streamed results and random-access equaliser reads.
// Revision : 1.0 - initial release
// ============================================================================
module dmrs_ch_avg_acc
    import ch_avg_pkg::*;
#(
    parameter int WORD_LENGTH = 8,
    parameter int DEPTH       = 240,
    parameter int MAX_SYMBOLS = 4,
    parameter int RECIP_FRAC  = 12,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int NSW        = $clog2(MAX_SYMBOLS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NSW-1:0]         num_sym,
    input  logic                   in_valid,
    input  logic [WORD_LENGTH-1:0] in_i,
    input  logic [WORD_LENGTH-1:0] in_q,
    input  logic [ADDR_WIDTH-1:0]  in_idx,
    input  logic                   sym_done,
    output logic                   out_valid,
    output logic [WORD_LENGTH-1:0] out_i,
    output logic [WORD_LENGTH-1:0] out_q,
    output logic [ADDR_WIDTH-1:0]  out_idx,
    output logic                   done,
    input  logic                   eq_read_enable,
    input  logic [ADDR_WIDTH-1:0]  eq_read_addr,
    output logic                   eq_rd_valid,
    output logic [WORD_LENGTH-1:0] eq_rd_i,
    output logic [WORD_LENGTH-1:0] eq_rd_q,
    output logic                   err
);

    localparam int ACC_W   = acc_width(WORD_LENGTH, MAX_SYMBOLS);
    localparam int EXT_W   = ACC_W - WORD_LENGTH;
    localparam int RECIP_W = RECIP_FRAC + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [NSW-1:0]        MAX_CNT   = NSW'(MAX_SYMBOLS);

    logic        [RECIP_W-1:0]     recip_tab [MAX_SYMBOLS+1];

    logic signed [ACC_W-1:0]       acc_re_q  [DEPTH];
    logic signed [ACC_W-1:0]       acc_im_q  [DEPTH];
    logic        [NSW-1:0]         hit_q     [DEPTH];
    logic        [WORD_LENGTH-1:0] res_re_q  [DEPTH];
    logic        [WORD_LENGTH-1:0] res_im_q  [DEPTH];

    state_e                        state_q;
    logic        [NSW-1:0]         num_sym_q;
    logic        [NSW-1:0]         sym_cnt_q;
    logic        [ADDR_WIDTH-1:0]  norm_idx_q;
    logic                          err_q;
    logic                          out_valid_q;
    logic                          out_last_q;
    logic        [ADDR_WIDTH-1:0]  out_idx_q;
    logic                          done_q;
    logic                          rd_valid_q;
    logic        [WORD_LENGTH-1:0] rd_re_q;
    logic        [WORD_LENGTH-1:0] rd_im_q;

    logic                          w_num_ok;
    logic                          w_idx_ok;
    logic                          w_rd_ok;
    logic        [ADDR_WIDTH-1:0]  w_wr_addr;
    logic        [ADDR_WIDTH-1:0]  w_rd_addr;
    logic signed [ACC_W-1:0]       w_ext_re;
    logic signed [ACC_W-1:0]       w_ext_im;
    logic        [NSW-1:0]         w_sym_next;
    logic                          w_norm_fire;
    logic                          w_rd_fire;
    logic        [RECIP_W-1:0]     w_recip;
    logic        [WORD_LENGTH-1:0] w_avg_re;
    logic        [WORD_LENGTH-1:0] w_avg_im;
    logic        [WORD_LENGTH-1:0] w_out_re;
    logic        [WORD_LENGTH-1:0] w_out_im;

    generate
        for (genvar c = 0; c <= MAX_SYMBOLS; c++) begin : g_recip
            assign recip_tab[c] = RECIP_W'(recip(c, RECIP_FRAC));
        end
    endgenerate

    assign w_num_ok    = (num_sym != '0) && (num_sym <= MAX_CNT);
    assign w_idx_ok    = {1'b0, in_idx} < DEPTH_EXT;
    assign w_rd_ok     = {1'b0, eq_read_addr} < DEPTH_EXT;
    assign w_wr_addr   = w_idx_ok ? in_idx : '0;
    assign w_rd_addr   = w_rd_ok ? eq_read_addr : '0;
    assign w_ext_re    = {{EXT_W{in_i[WORD_LENGTH-1]}}, in_i};
    assign w_ext_im    = {{EXT_W{in_q[WORD_LENGTH-1]}}, in_q};
    assign w_sym_next  = sym_cnt_q + NSW'(1);
    // A start during the sweep kills the current output beat immediately.
    assign w_norm_fire = (state_q == ST_NORM) && !start;
    assign w_rd_fire   = (state_q == ST_DONE) && eq_read_enable;
    assign w_recip     = recip_tab[hit_q[norm_idx_q]];

    ch_avg_norm #(
        .WORD_LENGTH (WORD_LENGTH),
        .ACC_W       (ACC_W),
        .RECIP_W     (RECIP_W),
        .RECIP_FRAC  (RECIP_FRAC)
    ) u_norm_re (
        .clk     (clk),
        .rst     (rst),
        .valid_i (w_norm_fire),
        .acc_i   (acc_re_q[norm_idx_q]),
        .recip_i (w_recip),
        .avg_d_o (w_avg_re),
        .avg_q_o (w_out_re)
    );

    ch_avg_norm #(
        .WORD_LENGTH (WORD_LENGTH),
        .ACC_W       (ACC_W),
        .RECIP_W     (RECIP_W),
        .RECIP_FRAC  (RECIP_FRAC)
    ) u_norm_im (
        .clk     (clk),
        .rst     (rst),
        .valid_i (w_norm_fire),
        .acc_i   (acc_im_q[norm_idx_q]),
        .recip_i (w_recip),
        .avg_d_o (w_avg_im),
        .avg_q_o (w_out_im)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            num_sym_q   <= '0;
            sym_cnt_q   <= '0;
            norm_idx_q  <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_re_q     <= '0;
            rd_im_q     <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                acc_re_q[e] <= '0;
                acc_im_q[e] <= '0;
                hit_q[e]    <= '0;
                res_re_q[e] <= '0;
                res_im_q[e] <= '0;
            end
        end else begin
            out_valid_q <= w_norm_fire;
            out_last_q  <= w_norm_fire && (norm_idx_q == LAST_IDX);
            done_q      <= out_last_q && !start;
            rd_valid_q  <= w_rd_fire;

            if (w_rd_fire) begin
                rd_re_q <= w_rd_ok ? res_re_q[w_rd_addr] : '0;
                rd_im_q <= w_rd_ok ? res_im_q[w_rd_addr] : '0;
            end

            if (w_norm_fire) begin
                out_idx_q            <= norm_idx_q;
                res_re_q[norm_idx_q] <= w_avg_re;
                res_im_q[norm_idx_q] <= w_avg_im;
            end

            if (start) begin
                sym_cnt_q  <= '0;
                norm_idx_q <= '0;
                if (w_num_ok) begin
                    state_q   <= ST_CLEAR;
                    num_sym_q <= num_sym;
                    err_q     <= 1'b0;
                end else begin
                    state_q <= ST_IDLE;
                    err_q   <= 1'b1;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_IDLE;
                    end
                    ST_CLEAR: begin
                        for (int e = 0; e < DEPTH; e++) begin
                            acc_re_q[e] <= '0;
                            acc_im_q[e] <= '0;
                            hit_q[e]    <= '0;
                        end
                        state_q <= ST_ACCUM;
                    end
                    ST_ACCUM: begin
                        if (in_valid) begin
                            if (!w_idx_ok || (hit_q[w_wr_addr] == MAX_CNT)) begin
                                err_q <= 1'b1;
                            end else begin
                                acc_re_q[w_wr_addr] <= acc_re_q[w_wr_addr] + w_ext_re;
                                acc_im_q[w_wr_addr] <= acc_im_q[w_wr_addr] + w_ext_im;
                                hit_q[w_wr_addr]    <= hit_q[w_wr_addr] + NSW'(1);
                            end
                        end
                        if (sym_done) begin
                            sym_cnt_q <= w_sym_next;
                            if (w_sym_next == num_sym_q) begin
                                state_q    <= ST_NORM;
                                norm_idx_q <= '0;
                            end
                        end
                    end
                    ST_NORM: begin
                        norm_idx_q <= norm_idx_q + ADDR_WIDTH'(1);
                        if (norm_idx_q == LAST_IDX) begin
                            state_q <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_DONE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_i       = w_out_re;
    assign out_q       = w_out_im;
    assign out_idx     = out_idx_q;
    assign done        = done_q;
    assign eq_rd_valid = rd_valid_q;
    assign eq_rd_i     = rd_re_q;
    assign eq_rd_q     = rd_im_q;
    assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmrs_ch_avg_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmrs_ch_avg_acc
// Purpose  : Directed self-checking bench for dmrs_ch_avg_acc.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmrs_ch_avg_acc;

    localparam int WL    = 8;
    localparam int DEPTH = 240;
    localparam int MAXS  = 4;
    localparam int RF    = 12;
    localparam int AW    = 8;
    localparam int NSW   = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [NSW-1:0] num_sym = '0;
    logic          in_valid = 1'b0;
    logic [WL-1:0] in_i = '0;
    logic [WL-1:0] in_q = '0;
    logic [AW-1:0] in_idx = '0;
    logic          sym_done = 1'b0;
    logic          out_valid;
    logic [WL-1:0] out_i;
    logic [WL-1:0] out_q;
    logic [AW-1:0] out_idx;
    logic          done;
    logic          eq_read_enable = 1'b0;
    logic [AW-1:0] eq_read_addr = '0;
    logic          eq_rd_valid;
    logic [WL-1:0] eq_rd_i;
    logic [WL-1:0] eq_rd_q;
    logic          err;

    int checks = 0;
    int errors = 0;

    logic signed [WL-1:0] cap_i [DEPTH];
    logic signed [WL-1:0] cap_q [DEPTH];
    int n_valid, first_k, done_k, seq_err;

    always #5 clk = ~clk;

    dmrs_ch_avg_acc #(
        .WORD_LENGTH (WL),
        .DEPTH       (DEPTH),
        .MAX_SYMBOLS (MAXS),
        .RECIP_FRAC  (RF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .num_sym        (num_sym),
        .in_valid       (in_valid),
        .in_i           (in_i),
        .in_q           (in_q),
        .in_idx         (in_idx),
        .sym_done       (sym_done),
        .out_valid      (out_valid),
        .out_i          (out_i),
        .out_q          (out_q),
        .out_idx        (out_idx),
        .done           (done),
        .eq_read_enable (eq_read_enable),
        .eq_read_addr   (eq_read_addr),
        .eq_rd_valid    (eq_rd_valid),
        .eq_rd_i        (eq_rd_i),
        .eq_rd_q        (eq_rd_q),
        .err            (err)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first ACCUM cycle (for a legal num_sym).
    task automatic do_start(input int n);
        start = 1'b1;
        num_sym = NSW'(n);
        cyc();
        start = 1'b0;
        cyc();
    endtask

    task automatic put(input int idx, input int vi, input int vq, input bit sd);
        in_valid = 1'b1;
        in_idx = AW'(idx);
        in_i = WL'(vi);
        in_q = WL'(vq);
        sym_done = sd;
        cyc();
        in_valid = 1'b0;
        sym_done = 1'b0;
    endtask

    task automatic sdone();
        sym_done = 1'b1;
        cyc();
        sym_done = 1'b0;
    endtask

    // Called in the cycle after the final sym_done; k counts cycles from it.
    task automatic collect();
        int exp_idx;
        exp_idx = 0;
        n_valid = 0;
        first_k = -1;
        done_k = -1;
        seq_err = 0;
        for (int e = 0; e < DEPTH; e++) begin
            cap_i[e] = 'x;
            cap_q[e] = 'x;
        end
        for (int k = 2; k <= DEPTH + 4; k++) begin
            cyc();
            if (out_valid === 1'b1) begin
                if (first_k < 0) first_k = k;
                if (out_idx !== AW'(exp_idx)) seq_err++;
                if (out_idx < AW'(DEPTH)) begin
                    cap_i[out_idx] = out_i;
                    cap_q[out_idx] = out_q;
                end
                exp_idx++;
                n_valid++;
            end
            if (done === 1'b1) begin
                if (done_k < 0) done_k = k;
                else seq_err++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
        checks++; if (eq_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0b exp 0", eq_rd_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", err); end
        checks++; if ({out_i, out_q, out_idx, eq_rd_i, eq_rd_q} !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", {out_i, out_q, out_idx, eq_rd_i, eq_rd_q}); end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_avg3();
        logic signed [WL-1:0] exp_i;
`ifdef CH_AVG_ROUND_EN
        exp_i = 8'sd100;
`else
        exp_i = 8'sd99;
`endif
        do_start(3);
        put(5, 100, -50, 1'b0);
        sdone();
        put(5, 100, -50, 1'b0);
        sdone();
        put(5, 100, -50, 1'b1);
        collect();
        checks++; if (n_valid !== DEPTH) begin errors++; $display("FAIL avg3_count got %0d exp %0d", n_valid, DEPTH); end
        checks++; if (first_k !== 2) begin errors++; $display("FAIL avg3_first_valid got %0d exp 2", first_k); end
        checks++; if (done_k !== DEPTH + 2) begin errors++; $display("FAIL avg3_done_cycle got %0d exp %0d", done_k, DEPTH + 2); end
        checks++; if (seq_err !== 0) begin errors++; $display("FAIL avg3_idx_seq got %0d exp 0", seq_err); end
        checks++; if (cap_i[5] !== exp_i) begin errors++; $display("FAIL avg3_i got %0d exp %0d", cap_i[5], exp_i); end
        checks++; if (cap_q[5] !== -8'sd50) begin errors++; $display("FAIL avg3_q got %0d exp -50", cap_q[5]); end
        checks++; if (cap_i[4] !== 8'sd0) begin errors++; $display("FAIL avg3_neighbour got %0d exp 0", cap_i[4]); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL avg3_err got %0b exp 0", err); end

        eq_read_enable = 1'b1;
        eq_read_addr = AW'(5);
        cyc();
        eq_read_enable = 1'b0;
        checks++; if (eq_rd_valid !== 1'b1) begin errors++; $display("FAIL rd_done_valid got %0b exp 1", eq_rd_valid); end
        checks++; if ($signed(eq_rd_i) !== exp_i) begin errors++; $display("FAIL rd_done_i got %0d exp %0d", $signed(eq_rd_i), exp_i); end
        checks++; if ($signed(eq_rd_q) !== -8'sd50) begin errors++; $display("FAIL rd_done_q got %0d exp -50", $signed(eq_rd_q)); end
        cyc();
        checks++; if (eq_rd_valid !== 1'b0) begin errors++; $display("FAIL rd_done_idle got %0b exp 0", eq_rd_valid); end
    endtask

    task automatic test_two_sym();
        do_start(2);
        eq_read_enable = 1'b1;
        eq_read_addr = AW'(5);
        cyc();
        eq_read_enable = 1'b0;
        checks++; if (eq_rd_valid !== 1'b0) begin errors++; $display("FAIL rd_accum_valid got %0b exp 0", eq_rd_valid); end
        put(0, -128, 127, 1'b1);
        put(0, -128, 127, 1'b1);
        collect();
        checks++; if (done_k !== DEPTH + 2) begin errors++; $display("FAIL two_done_cycle got %0d exp %0d", done_k, DEPTH + 2); end
        checks++; if (cap_i[0] !== -8'sd128) begin errors++; $display("FAIL two_i0 got %0d exp -128", cap_i[0]); end
        checks++; if (cap_q[0] !== 8'sd127) begin errors++; $display("FAIL two_q0 got %0d exp 127", cap_q[0]); end
        checks++; if (cap_i[1] !== 8'sd0) begin errors++; $display("FAIL two_i1 got %0d exp 0", cap_i[1]); end
        checks++; if (cap_q[1] !== 8'sd0) begin errors++; $display("FAIL two_q1 got %0d exp 0", cap_q[1]); end
        checks++; if (cap_i[5] !== 8'sd0) begin errors++; $display("FAIL two_cleared got %0d exp 0", cap_i[5]); end
    endtask

    task automatic test_partial();
        logic signed [WL-1:0] exp_q;
`ifdef CH_AVG_ROUND_EN
        exp_q = -8'sd30;
`else
        exp_q = -8'sd31;
`endif
        do_start(3);
        put(7, 40, -40, 1'b1);
        sdone();
        put(7, 20, -21, 1'b1);
        collect();
        checks++; if (n_valid !== DEPTH) begin errors++; $display("FAIL part_count got %0d exp %0d", n_valid, DEPTH); end
        checks++; if (cap_i[7] !== 8'sd30) begin errors++; $display("FAIL part_i got %0d exp 30", cap_i[7]); end
        checks++; if (cap_q[7] !== exp_q) begin errors++; $display("FAIL part_q got %0d exp %0d", cap_q[7], exp_q); end
    endtask

    task automatic test_err();
        do_start(4);
        put(DEPTH, 1, 1, 1'b0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_bad_idx got %0b exp 1", err); end
        repeat (4) put(3, 10, -10, 1'b0);
        put(3, 120, 120, 1'b0);
        repeat (3) sdone();
        sdone();
        collect();
        checks++; if (cap_i[3] !== 8'sd10) begin errors++; $display("FAIL err_overflow_i got %0d exp 10", cap_i[3]); end
        checks++; if (cap_q[3] !== -8'sd10) begin errors++; $display("FAIL err_overflow_q got %0d exp -10", cap_q[3]); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b exp 1", err); end

        start = 1'b1;
        num_sym = NSW'(1);
        cyc();
        start = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_start_clear got %0b exp 0", err); end

        start = 1'b1;
        num_sym = NSW'(0);
        cyc();
        start = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_num_zero got %0b exp 1", err); end
        sdone();
        n_valid = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (out_valid === 1'b1) n_valid++;
        end
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL err_stays_idle got %0d exp 0", n_valid); end

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_rst_clear got %0b exp 0", err); end

        start = 1'b1;
        num_sym = NSW'(5);
        cyc();
        start = 1'b0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_num_big got %0b exp 1", err); end
    endtask

    task automatic test_restart_norm();
        do_start(1);
        put(2, 50, 50, 1'b1);
        repeat (20) cyc();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rs_mid_norm got %0b exp 1", out_valid); end
        start = 1'b1;
        num_sym = NSW'(1);
        cyc();
        start = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rs_valid_drop got %0b exp 0", out_valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rs_no_done got %0b exp 0", done); end
        cyc();
        checks++; if ((out_valid | done) !== 1'b0) begin errors++; $display("FAIL rs_quiet got %0b exp 0", out_valid | done); end
        put(2, -60, 33, 1'b1);
        collect();
        checks++; if (n_valid !== DEPTH) begin errors++; $display("FAIL rs_count got %0d exp %0d", n_valid, DEPTH); end
        checks++; if (done_k !== DEPTH + 2) begin errors++; $display("FAIL rs_done_cycle got %0d exp %0d", done_k, DEPTH + 2); end
        checks++; if (seq_err !== 0) begin errors++; $display("FAIL rs_idx_seq got %0d exp 0", seq_err); end
        checks++; if (cap_i[2] !== -8'sd60) begin errors++; $display("FAIL rs_i got %0d exp -60", cap_i[2]); end
        checks++; if (cap_q[2] !== 8'sd33) begin errors++; $display("FAIL rs_q got %0d exp 33", cap_q[2]); end
    endtask

    initial begin
        test_reset();
        test_avg3();
        test_two_sym();
        test_partial();
        test_err();
        test_restart_norm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
